// File: rtl/qspi_flash_read_sequencer_if.sv
// Request, read-stream and transceiver signals of the QSPI flash read sequencer.
// The master modport is the sequencer's view. The slave modport is the view of
// the requester, the consumer and the transceiver.
interface qspi_flash_read_sequencer_if;
   // request channel
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [15:0] req_len;
   // read-data stream
   logic        rd_valid;
   logic        rd_ready;
   logic [7:0]  rd_data;
   logic        rd_last;
   // status
   logic        busy;
   logic        done;
   // flash chip select and byte transceiver
   logic        cs_n;
   logic        xcvr_shift_en;
   logic [7:0]  xcvr_tx_data;
   logic        xcvr_shift_done;
   logic [7:0]  xcvr_rx_data;

   modport master (
      input  req_valid, req_addr, req_len, rd_ready, xcvr_shift_done, xcvr_rx_data,
      output req_ready, rd_valid, rd_data, rd_last, busy, done, cs_n,
             xcvr_shift_en, xcvr_tx_data
   );

   modport slave (
      output req_valid, req_addr, req_len, rd_ready, xcvr_shift_done, xcvr_rx_data,
      input  req_ready, rd_valid, rd_data, rd_last, busy, done, cs_n,
             xcvr_shift_en, xcvr_tx_data
   );
endinterface

// File: rtl/qspi_flash_read_sequencer.sv
// QSPI flash read sequencer.
// Runs one flash read per accepted request: chip select, command byte, address
// bytes, dummy bytes, then req_len data bytes.
// The byte transceiver has no chip select, so this block owns cs_n.
// Each byte is one shift_en pulse followed by a wait for shift_done.
// Received data bytes go through a one-byte holding register to a valid/ready
// stream. A stalled consumer holds off the next data shift.
module qspi_flash_read_sequencer #(
   parameter logic [7:0] READ_CMD           = 8'h03,
   parameter int         ADDR_BYTES         = 3,  // 3 or 4
   parameter int         DUMMY_BYTES        = 0,  // 0..15
   parameter int         CS_SETUP_CYCLES    = 2,  // >= 1
   parameter int         CS_HOLD_CYCLES     = 2,  // >= 1
   parameter int         CS_DESELECT_CYCLES = 4   // >= 1
) (
   input logic                          clk,
   input logic                          rst_n,
   qspi_flash_read_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_DESEL
   } state_t;

   localparam logic [15:0] SETUP_LAST  = 16'(CS_SETUP_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST   = 16'(CS_HOLD_CYCLES - 1);
   localparam logic [15:0] DESEL_LAST  = 16'(CS_DESELECT_CYCLES - 1);
   localparam logic [3:0]  ADDR_LAST   = 4'(ADDR_BYTES - 1);
   localparam logic [3:0]  DUMMY_LAST  = 4'((DUMMY_BYTES == 0) ? 0 : DUMMY_BYTES - 1);
   localparam int          ADDR_MSB    = 8 * ADDR_BYTES - 1;

   state_t      state;
   logic [15:0] cycle_cnt;     // SETUP / HOLD / DESEL timing
   logic [15:0] remaining;     // data bytes still to receive
   logic [3:0]  byte_cnt;      // index within ADDR / DUMMY
   logic [31:0] addr_q;        // address, shifted left as bytes go out
   logic        wait_done;     // a byte shift is in flight
   logic        cs_n_q;
   logic        shift_en_q;
   logic [7:0]  tx_q;
   logic        rd_valid_q;
   logic [7:0]  rd_data_q;
   logic        rd_last_q;
   logic        done_q;

   logic        rd_pop;        // holding register emptied this cycle
   logic        hold_free;     // holding register empty, or emptied this cycle

   assign rd_pop    = rd_valid_q && bus.rd_ready;
   assign hold_free = !rd_valid_q || bus.rd_ready;

   // After the last header byte: go to DATA, or go straight to HOLD for a zero-length read.
   function automatic state_t after_header(input logic [15:0] len_left);
      return (len_left == 16'd0) ? S_HOLD : S_DATA;
   endfunction

   // Transaction FSM. All outputs are registered here.
   // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cycle_cnt  <= '0;
         remaining  <= '0;
         byte_cnt   <= '0;
         addr_q     <= '0;
         wait_done  <= 1'b0;
         cs_n_q     <= 1'b1;
         shift_en_q <= 1'b0;
         tx_q       <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         shift_en_q <= 1'b0;
         done_q     <= 1'b0;

         // The consumer empties the holding register. A load below takes precedence.
         if (rd_pop) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
         end

         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  addr_q    <= bus.req_addr;
                  remaining <= bus.req_len;
                  cs_n_q    <= 1'b0;
                  cycle_cnt <= '0;
                  state     <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (cycle_cnt == SETUP_LAST) begin
                  cycle_cnt <= '0;
                  state     <= S_CMD;
               end else begin
                  cycle_cnt <= cycle_cnt + 16'd1;
               end
            end

            S_CMD: begin
               if (!wait_done) begin
                  shift_en_q <= 1'b1;
                  tx_q       <= READ_CMD;
                  wait_done  <= 1'b1;
               end else if (bus.xcvr_shift_done) begin
                  wait_done <= 1'b0;
                  byte_cnt  <= '0;
                  state     <= S_ADDR;
               end
            end

            S_ADDR: begin
               if (!wait_done) begin
                  shift_en_q <= 1'b1;
                  tx_q       <= addr_q[ADDR_MSB -: 8];
                  addr_q     <= addr_q << 8;
                  wait_done  <= 1'b1;
               end else if (bus.xcvr_shift_done) begin
                  wait_done <= 1'b0;
                  if (byte_cnt == ADDR_LAST) begin
                     byte_cnt  <= '0;
                     cycle_cnt <= '0;
                     state     <= (DUMMY_BYTES != 0) ? S_DUMMY : after_header(remaining);
                  end else begin
                     byte_cnt <= byte_cnt + 4'd1;
                  end
               end
            end

            S_DUMMY: begin
               if (!wait_done) begin
                  shift_en_q <= 1'b1;
                  tx_q       <= 8'h00;
                  wait_done  <= 1'b1;
               end else if (bus.xcvr_shift_done) begin
                  // The byte received during a dummy shift is discarded.
                  wait_done <= 1'b0;
                  if (byte_cnt == DUMMY_LAST) begin
                     byte_cnt  <= '0;
                     cycle_cnt <= '0;
                     state     <= after_header(remaining);
                  end else begin
                     byte_cnt <= byte_cnt + 4'd1;
                  end
               end
            end

            S_DATA: begin
               if (!wait_done) begin
                  // Start a shift only when its byte will have somewhere to land.
                  if (hold_free) begin
                     shift_en_q <= 1'b1;
                     tx_q       <= 8'h00;
                     wait_done  <= 1'b1;
                  end
               end else if (bus.xcvr_shift_done) begin
                  wait_done  <= 1'b0;
                  rd_data_q  <= bus.xcvr_rx_data;
                  rd_valid_q <= 1'b1;
                  rd_last_q  <= (remaining == 16'd1);
                  if (remaining != 16'd0) begin
                     remaining <= remaining - 16'd1;
                  end
                  if (remaining <= 16'd1) begin
                     cycle_cnt <= '0;
                     state     <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               if (cycle_cnt != HOLD_LAST) begin
                  cycle_cnt <= cycle_cnt + 16'd1;
               end else if (hold_free) begin
                  cs_n_q    <= 1'b1;
                  done_q    <= 1'b1;
                  cycle_cnt <= '0;
                  state     <= S_DESEL;
               end
            end

            S_DESEL: begin
               if (cycle_cnt == DESEL_LAST) begin
                  cycle_cnt <= '0;
                  state     <= S_IDLE;
               end else begin
                  cycle_cnt <= cycle_cnt + 16'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready     = (state == S_IDLE);
   assign bus.busy          = (state != S_IDLE);
   assign bus.done          = done_q;
   assign bus.cs_n          = cs_n_q;
   assign bus.xcvr_shift_en = shift_en_q;
   assign bus.xcvr_tx_data  = tx_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.rd_last       = rd_last_q;

endmodule

// File: tb/tb_qspi_flash_read_sequencer.sv
// Directed testbench for qspi_flash_read_sequencer.
// Instance 0 uses 3 address bytes and no dummy bytes.
// Instance 1 uses 4 address bytes and 1 dummy byte.
// The transceiver model answers each shift 2 cycles later.
// The received byte is 8'hC0 plus the shift's index within the current chip-select window.
`timescale 1ns/1ps
module tb_qspi_flash_read_sequencer;

   localparam int XCVR_LAT = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      qspi_flash_read_sequencer_if bus ();

      qspi_flash_read_sequencer #(
         .READ_CMD           (8'h03),
         .ADDR_BYTES         ((g == 0) ? 3 : 4),
         .DUMMY_BYTES        ((g == 0) ? 0 : 1),
         .CS_SETUP_CYCLES    (2),
         .CS_HOLD_CYCLES     (2),
         .CS_DESELECT_CYCLES (4)
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      logic [7:0] tx_log [0:127];
      logic [7:0] rd_log [0:63];
      int   tx_cnt = 0, rd_cnt = 0, last_cnt = 0, last_idx = -1;
      int   done_cnt = 0, rdv_cnt = 0, shift_idx = 0;
      int   low_run = 0, setup_low = 0, hi_run = 0, hi_at_ready = 0;
      logic first_pending = 1'b1;
      logic rr_prev = 1'b0;

      // Transceiver model: logs each tx byte and answers after XCVR_LAT cycles.
      initial begin
         bus.xcvr_shift_done = 1'b0;
         bus.xcvr_rx_data    = 8'h00;
         forever begin
            @(negedge clk);
            if (bus.cs_n) shift_idx = 0;
            if (bus.xcvr_shift_en) begin
               if (tx_cnt < 128) tx_log[tx_cnt] = bus.xcvr_tx_data;
               tx_cnt++;
               repeat (XCVR_LAT) @(negedge clk);
               bus.xcvr_rx_data    = 8'hC0 + 8'(shift_idx);
               shift_idx++;
               bus.xcvr_shift_done = 1'b1;
               @(negedge clk);
               bus.xcvr_shift_done = 1'b0;
            end
         end
      end

      // Monitor: read-stream handshakes, done pulses, chip-select timing.
      initial begin
         forever begin
            @(negedge clk);
            if (bus.rd_valid && bus.rd_ready) begin
               if (rd_cnt < 64) rd_log[rd_cnt] = bus.rd_data;
               if (bus.rd_last) begin
                  last_cnt++;
                  last_idx = rd_cnt;
               end
               rd_cnt++;
            end
            if (bus.rd_valid) rdv_cnt++;
            if (bus.done) done_cnt++;
            if (bus.cs_n) begin
               low_run       = 0;
               first_pending = 1'b1;
               if (bus.req_ready && !rr_prev) hi_at_ready = hi_run;
               hi_run++;
            end else begin
               hi_run = 0;
               if (bus.xcvr_shift_en && first_pending) begin
                  setup_low     = low_run;
                  first_pending = 1'b0;
               end
               low_run++;
            end
            rr_prev = bus.req_ready;
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic at_pos();
      @(posedge clk);
      #1;
   endtask

   function automatic int done_of(input int g);
      return (g == 0) ? g_dut[0].done_cnt : g_dut[1].done_cnt;
   endfunction

   function automatic int tx_cnt_of(input int g);
      return (g == 0) ? g_dut[0].tx_cnt : g_dut[1].tx_cnt;
   endfunction

   function automatic int rd_cnt_of(input int g);
      return (g == 0) ? g_dut[0].rd_cnt : g_dut[1].rd_cnt;
   endfunction

   function automatic int last_cnt_of(input int g);
      return (g == 0) ? g_dut[0].last_cnt : g_dut[1].last_cnt;
   endfunction

   function automatic logic [7:0] tx_at(input int g, input int k);
      if (k < 0 || k > 127) return 8'hxx;
      return (g == 0) ? g_dut[0].tx_log[k] : g_dut[1].tx_log[k];
   endfunction

   function automatic logic [7:0] rd_at(input int g, input int k);
      if (k < 0 || k > 63) return 8'hxx;
      return (g == 0) ? g_dut[0].rd_log[k] : g_dut[1].rd_log[k];
   endfunction

   task automatic drive_req(input int g, input logic v, input logic [31:0] a, input logic [15:0] l);
      if (g == 0) begin
         g_dut[0].bus.req_valid = v;
         g_dut[0].bus.req_addr  = a;
         g_dut[0].bus.req_len   = l;
      end else begin
         g_dut[1].bus.req_valid = v;
         g_dut[1].bus.req_addr  = a;
         g_dut[1].bus.req_len   = l;
      end
   endtask

   // One-cycle request strobe; the DUT must be idle.
   task automatic run_req(input int g, input logic [31:0] a, input logic [15:0] l);
      at_pos();
      drive_req(g, 1'b1, a, l);
      at_pos();
      drive_req(g, 1'b0, a, l);
   endtask

   task automatic wait_done(input int g, input int target, input string tag);
      for (int i = 0; i < 500 && done_of(g) < target; i++) tick();
      check(tag, done_of(g), target);
   endtask

   // exp holds n bytes, first byte in the most significant position.
   task automatic check_tx(input string tag, input int g, input int base, input int n,
                           input logic [63:0] exp);
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         e = exp[8*(n-1-i) +: 8];
         check($sformatf("%s_tx%0d", tag, i), tx_at(g, base + i), e);
      end
   endtask

   task automatic check_rd(input string tag, input int g, input int base, input int n,
                           input logic [63:0] exp);
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         e = exp[8*(n-1-i) +: 8];
         check($sformatf("%s_rd%0d", tag, i), rd_at(g, base + i), e);
      end
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------------- stimulus
   int tx0, rd0, dn0, lc0, rdv0, hi_cnt, se_cnt;

   initial begin
      drive_req(0, 1'b0, 32'h0, 16'h0);
      drive_req(1, 1'b0, 32'h0, 16'h0);
      g_dut[0].bus.rd_ready = 1'b1;
      g_dut[1].bus.rd_ready = 1'b1;

      // Reset state
      #12;
      check("rst_cs_n",     g_dut[0].bus.cs_n,          1'b1);
      check("rst_shift_en", g_dut[0].bus.xcvr_shift_en, 1'b0);
      check("rst_tx_data",  g_dut[0].bus.xcvr_tx_data,  8'h00);
      check("rst_rd_valid", g_dut[0].bus.rd_valid,      1'b0);
      check("rst_rd_last",  g_dut[0].bus.rd_last,       1'b0);
      check("rst_rd_data",  g_dut[0].bus.rd_data,       8'h00);
      check("rst_done",     g_dut[0].bus.done,          1'b0);
      check("rst_busy",     g_dut[0].bus.busy,          1'b0);
      check("rst_cs_n_b",   g_dut[1].bus.cs_n,          1'b1);
      at_pos();
      rst_n = 1'b1;
      tick();
      check("rst_req_ready", g_dut[0].bus.req_ready, 1'b1);
      repeat (2) tick();

      // T1: addr 0x123456, len 4, consumer always ready
      tx0 = tx_cnt_of(0); rd0 = rd_cnt_of(0); dn0 = done_of(0); lc0 = last_cnt_of(0);
      run_req(0, 32'h0012_3456, 16'd4);
      wait_done(0, dn0 + 1, "t1_done");
      repeat (10) tick();
      check("t1_one_done", done_of(0), dn0 + 1);
      check("t1_tx_count", tx_cnt_of(0) - tx0, 8);
      check_tx("t1", 0, tx0, 8, 64'h0312_3456_0000_0000);
      check("t1_rd_count", rd_cnt_of(0) - rd0, 4);
      check_rd("t1", 0, rd0, 4, 64'hC4C5_C6C7);
      check("t1_last_count", last_cnt_of(0) - lc0, 1);
      check("t1_last_idx", g_dut[0].last_idx, rd0 + 3);
      check("t1_cs_setup", 32'(g_dut[0].setup_low >= 2), 1);

      // T2: 4 address bytes plus 1 dummy byte; the dummy rx byte (C5) is not output
      tx0 = tx_cnt_of(1); rd0 = rd_cnt_of(1); dn0 = done_of(1);
      run_req(1, 32'hAABB_CCDD, 16'd2);
      wait_done(1, dn0 + 1, "t2_done");
      repeat (10) tick();
      check("t2_tx_count", tx_cnt_of(1) - tx0, 8);
      check_tx("t2", 1, tx0, 8, 64'h03AA_BBCC_DD00_0000);
      check("t2_rd_count", rd_cnt_of(1) - rd0, 2);
      check_rd("t2", 1, rd0, 2, 64'hC6C7);

      // T3: consumer stalls for 20 cycles with byte 1 held, len 3
      tx0 = tx_cnt_of(0); rd0 = rd_cnt_of(0); dn0 = done_of(0); lc0 = last_cnt_of(0);
      g_dut[0].bus.rd_ready = 1'b0;
      run_req(0, 32'h0000_0100, 16'd3);
      for (int i = 0; i < 200 && !g_dut[0].bus.rd_valid; i++) tick();
      check("t3_byte1_valid", g_dut[0].bus.rd_valid, 1'b1);
      hi_cnt = 0; se_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (g_dut[0].bus.cs_n) hi_cnt++;
         if (g_dut[0].bus.xcvr_shift_en) se_cnt++;
      end
      check("t3_stall_shifts", se_cnt, 0);
      check("t3_stall_cs_high", hi_cnt, 0);
      check("t3_stall_hold_valid", g_dut[0].bus.rd_valid, 1'b1);
      check("t3_stall_hold_data", g_dut[0].bus.rd_data, 8'hC4);
      at_pos();
      g_dut[0].bus.rd_ready = 1'b1;
      wait_done(0, dn0 + 1, "t3_done");
      repeat (10) tick();
      check("t3_tx_count", tx_cnt_of(0) - tx0, 7);
      check("t3_rd_count", rd_cnt_of(0) - rd0, 3);
      check_rd("t3", 0, rd0, 3, 64'hC4C5C6);
      check("t3_last_idx", g_dut[0].last_idx, rd0 + 2);
      check("t3_last_count", last_cnt_of(0) - lc0, 1);

      // T4: zero-length read; header still goes out, nothing is output
      tx0 = tx_cnt_of(0); rdv0 = g_dut[0].rdv_cnt; dn0 = done_of(0);
      run_req(0, 32'h0000_0010, 16'd0);
      wait_done(0, dn0 + 1, "t4_done");
      repeat (10) tick();
      check("t4_tx_count", tx_cnt_of(0) - tx0, 4);
      check_tx("t4", 0, tx0, 4, 64'h0300_0010);
      check("t4_no_rd_valid", g_dut[0].rdv_cnt - rdv0, 0);
      check("t4_desel_time", 32'(g_dut[0].hi_at_ready >= 4), 1);
      check("t4_req_ready", g_dut[0].bus.req_ready, 1'b1);

      // T5: reset asserted while data byte 2 is in flight
      tx0 = tx_cnt_of(0); rd0 = rd_cnt_of(0);
      run_req(0, 32'h0000_0200, 16'd4);
      for (int i = 0; i < 200 && tx_cnt_of(0) < tx0 + 6; i++) tick();
      check("t5_reach_byte2", tx_cnt_of(0) - tx0, 6);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_cs_n", g_dut[0].bus.cs_n, 1'b1);
      check("t5_rst_busy", g_dut[0].bus.busy, 1'b0);
      at_pos();
      rst_n = 1'b1;
      repeat (6) tick();
      check("t5_stale_busy", g_dut[0].bus.busy, 1'b0);
      check("t5_stale_rd_valid", g_dut[0].bus.rd_valid, 1'b0);
      check("t5_rd_count", rd_cnt_of(0) - rd0, 1);
      check("t5_tx_count", tx_cnt_of(0) - tx0, 6);

      // T5b: next request after the abort; upper address bits are ignored
      tx0 = tx_cnt_of(0); rd0 = rd_cnt_of(0); dn0 = done_of(0); lc0 = last_cnt_of(0);
      run_req(0, 32'hFFAB_CDEF, 16'd2);
      wait_done(0, dn0 + 1, "t5b_done");
      repeat (10) tick();
      check("t5b_tx_count", tx_cnt_of(0) - tx0, 6);
      check_tx("t5b", 0, tx0, 6, 64'h03AB_CDEF_0000);
      check("t5b_rd_count", rd_cnt_of(0) - rd0, 2);
      check_rd("t5b", 0, rd0, 2, 64'hC4C5);
      check("t5b_last_count", last_cnt_of(0) - lc0, 1);

      // T6: req_valid held high; request fields change while busy
      tx0 = tx_cnt_of(0); rd0 = rd_cnt_of(0); dn0 = done_of(0); lc0 = last_cnt_of(0);
      at_pos();
      drive_req(0, 1'b1, 32'h0011_1111, 16'd1);
      at_pos();
      drive_req(0, 1'b1, 32'h0022_2222, 16'd2);
      wait_done(0, dn0 + 1, "t6_done1");
      for (int i = 0; i < 20 && !g_dut[0].bus.req_ready; i++) tick();
      check("t6_ready_again", g_dut[0].bus.req_ready, 1'b1);
      at_pos();
      drive_req(0, 1'b0, 32'h0, 16'h0);
      wait_done(0, dn0 + 2, "t6_done2");
      repeat (20) tick();
      check("t6_done_total", done_of(0), dn0 + 2);
      check("t6_busy_end", g_dut[0].bus.busy, 1'b0);
      check("t6_tx_count", tx_cnt_of(0) - tx0, 11);
      check_tx("t6a", 0, tx0, 5, 64'h03_1111_1100);
      check_tx("t6b", 0, tx0 + 5, 6, 64'h0322_2222_0000);
      check("t6_rd_count", rd_cnt_of(0) - rd0, 3);
      check_rd("t6", 0, rd0, 3, 64'hC4C4C5);
      check("t6_last_count", last_cnt_of(0) - lc0, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
